// File: rtl/dbg_bus_master.sv
// Byte-stream debug bus master.
// Takes a command byte, 4 address bytes and (for writes) 4 data bytes, issues one
// bus request, waits for completion or timeout, and streams back a status byte
// plus (for reads that completed) 4 read-data bytes.
//
// Handshake rule for both byte streams: a byte moves on a rising clk edge where
// valid and ready are both high; the sender holds valid and data stable until
// that edge, and ready never depends combinationally on valid.
module dbg_bus_master #(
  parameter int unsigned TIMEOUT = 1023  // WAIT cycles before abort, must be >= 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        outreq,
  output logic        outwr,
  output logic [31:0] outaddr,
  output logic [31:0] outwdata,
  output logic [3:0]  outwstrb,
  input  logic        outack,
  input  logic        outerr,
  input  logic [31:0] outrdata,
  output logic [2:0]  dbg_state_o
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_OK  = 2'd0;
  localparam logic [1:0] ST_ERR = 2'd1;
  localparam logic [1:0] ST_TMO = 2'd2;

  typedef enum logic [2:0] {
    S_CMD  = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_REQ  = 3'd3,
    S_WAIT = 3'd4,
    S_RESP = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic          wr_q, wr_d;
  logic [3:0]    strb_q, strb_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [1:0]    status_q, status_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [2:0]    ridx_q, ridx_d;

  logic in_hs;
  logic out_hs;
  logic resp_last;

  // Byte counter doubled as a bit offset into the 32-bit shift targets.
  logic [4:0] boff;
  assign boff = {bcnt_q, 3'b000};

  assign in_hs  = in_valid & in_ready_q;
  assign out_hs = out_valid & out_ready;

  // Writes and timeouts stop after the status byte; reads that completed send 4 more.
  assign resp_last = (ridx_q == 3'd4) || ((ridx_q == 3'd0) && (wr_q || (status_q == ST_TMO)));

  // State and datapath registers; reset clears everything and drops in_ready.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_CMD;
      in_ready_q <= 1'b0;
      bcnt_q     <= 2'd0;
      wr_q       <= 1'b0;
      strb_q     <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      wcnt_q     <= '0;
      status_q   <= ST_OK;
      rdata_q    <= 32'd0;
      ridx_q     <= 3'd0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      bcnt_q     <= bcnt_d;
      wr_q       <= wr_d;
      strb_q     <= strb_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wcnt_q     <= wcnt_d;
      status_q   <= status_d;
      rdata_q    <= rdata_d;
      ridx_q     <= ridx_d;
    end
  end

  // Next-state logic: command assembly, bus request, wait/timeout, response stream.
  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    wr_d     = wr_q;
    strb_d   = strb_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wcnt_d   = wcnt_q;
    status_d = status_q;
    rdata_d  = rdata_q;
    ridx_d   = ridx_q;

    case (state_q)
      S_CMD: begin
        if (in_hs) begin
          wr_d    = in_data[7];
          strb_d  = in_data[3:0];
          bcnt_d  = 2'd0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (in_hs) begin
          addr_d[boff +: 8] = in_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) state_d = wr_q ? S_DATA : S_REQ;
        end
      end
      S_DATA: begin
        if (in_hs) begin
          wdata_d[boff +: 8] = in_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) state_d = S_REQ;
        end
      end
      S_REQ: begin
        // outack is deliberately not looked at here.
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // An ack on the final counted cycle still beats the timeout.
        if (outack) begin
          status_d = outerr ? ST_ERR : ST_OK;
          rdata_d  = outrdata;
          ridx_d   = 3'd0;
          state_d  = S_RESP;
        end else if (wcnt_q == CW'(TIMEOUT - 1)) begin
          status_d = ST_TMO;
          ridx_d   = 3'd0;
          state_d  = S_RESP;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      S_RESP: begin
        if (out_hs) begin
          if (resp_last) begin
            ridx_d  = 3'd0;
            state_d = S_CMD;
          end else begin
            ridx_d = ridx_q + 3'd1;
          end
        end
      end
      default: state_d = S_CMD;
    endcase
  end

  // in_ready is registered so it stays low until the first clock after reset.
  assign in_ready_d = (state_d == S_CMD) || (state_d == S_ADDR) || (state_d == S_DATA);

  // Response byte select: status first, then read data least significant byte first.
  always_comb begin
    out_data = 8'h00;
    case (ridx_q)
      3'd0:    out_data = {6'd0, status_q};
      3'd1:    out_data = rdata_q[7:0];
      3'd2:    out_data = rdata_q[15:8];
      3'd3:    out_data = rdata_q[23:16];
      3'd4:    out_data = rdata_q[31:24];
      default: out_data = 8'h00;
    endcase
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q == S_RESP);
  assign outreq      = (state_q == S_REQ);
  assign outwr       = wr_q;
  assign outaddr     = addr_q;
  assign outwdata    = wdata_q;
  assign outwstrb    = wr_q ? strb_q : 4'b0000;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dbg_bus_master.sv
// Directed bench for dbg_bus_master: table of transactions plus hand-written
// sequences for late ack, backpressure and mid-transaction reset.
module tb_dbg_bus_master;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b1;
  logic        outreq;
  logic        outwr;
  logic [31:0] outaddr;
  logic [31:0] outwdata;
  logic [3:0]  outwstrb;
  logic        outack = 1'b0;
  logic        outerr = 1'b0;
  logic [31:0] outrdata = 32'h0;
  logic [2:0]  dbg_state;

  dbg_bus_master #(.TIMEOUT(15)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .outreq(outreq), .outwr(outwr), .outaddr(outaddr), .outwdata(outwdata),
    .outwstrb(outwstrb), .outack(outack), .outerr(outerr), .outrdata(outrdata),
    .dbg_state_o(dbg_state)
  );

  // Clock and cycle/request bookkeeping
  always #5 clk = ~clk;

  int cyc = 0;
  int req_pulses = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (outreq) req_pulses <= req_pulses + 1;
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          do_ack;
    int          ack_dly;    // negedges after outreq is seen; 0 = during REQ cycle
    logic        err;
    logic [31:0] rdata;
    logic [7:0]  exp_status;
    logic [3:0]  exp_strb;
    int          exp_lat;    // cycles from outreq to first out_valid
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver tasks: all called and returning at a falling edge
  task automatic send_byte(input logic [7:0] b);
    int n;
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("in_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] wdata);
    send_byte(cmd);
    for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
    if (cmd[7]) for (int i = 0; i < 4; i++) send_byte(wdata[8*i +: 8]);
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!outreq && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("outreq_timeout", 32'd0, 32'd1);
  endtask

  task automatic drive_ack(input int dly, input logic err, input logic [31:0] rdata);
    repeat (dly) @(negedge clk);
    outack   = 1'b1;
    outerr   = err;
    outrdata = rdata;
    @(negedge clk);
    outack   = 1'b0;
    outerr   = 1'b0;
    outrdata = 32'h0;
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("out_valid_timeout", 32'd0, 32'd1);
  endtask

  // Scoreboard: drain the response and compare against the expected queue
  task automatic recv_all();
    int n;
    logic [7:0] e;
    out_ready = 1'b1;
    while (exp_q.size() > 0) begin
      n = 0;
      while (!out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) begin
        check("resp_timeout", 32'd0, 32'd1);
        exp_q.delete();
        return;
      end
      e = exp_q.pop_front();
      check("resp_byte", {24'd0, out_data}, {24'd0, e});
      @(negedge clk);
    end
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic push_resp(input vec_t v);
    exp_q.push_back(v.exp_status);
    if (!v.cmd[7] && v.exp_status != 8'h02)
      for (int i = 0; i < 4; i++) exp_q.push_back(v.rdata[8*i +: 8]);
  endtask

  task automatic apply(input vec_t v);
    int p0, t0;
    p0 = req_pulses;
    send_cmd(v.cmd, v.addr, v.wdata);
    wait_req();
    t0 = cyc;
    check("outaddr", outaddr, v.addr);
    check("outwr", {31'd0, outwr}, {31'd0, v.cmd[7]});
    check("outwstrb", {28'd0, outwstrb}, {28'd0, v.exp_strb});
    if (v.cmd[7]) check("outwdata", outwdata, v.wdata);
    push_resp(v);
    if (v.do_ack) drive_ack(v.ack_dly, v.err, v.rdata);
    wait_out_valid();
    check("resp_latency", cyc - t0, v.exp_lat);
    check("outaddr_held", outaddr, v.addr);
    recv_all();
    check("req_pulse_count", req_pulses - p0, 32'd1);
  endtask

  initial begin
    int p0;
    vec_t rv;

    //            cmd    addr          wdata         ack dly err rdata         st     strb  lat
    vecs[0] = '{8'h8F, 32'h0000_0100, 32'h1234_5678, 1, 3,  0, 32'h0,         8'h00, 4'hF, 4};
    vecs[1] = '{8'h00, 32'h0000_0204, 32'h0,         1, 2,  0, 32'hDEAD_BEEF, 8'h00, 4'h0, 3};
    vecs[2] = '{8'h00, 32'h0000_1000, 32'h0,         1, 1,  1, 32'h0,         8'h01, 4'h0, 2};
    vecs[3] = '{8'h00, 32'h0000_0040, 32'h0,         0, 0,  0, 32'h0,         8'h02, 4'h0, 16};
    vecs[4] = '{8'hF5, 32'hA5A5_1234, 32'h0BAD_F00D, 1, 5,  1, 32'h0,         8'h01, 4'h5, 6};
    vecs[5] = '{8'h7A, 32'hFFFF_FFFC, 32'h0,         1, 15, 0, 32'h0102_0304, 8'h00, 4'h0, 16};
    vecs[6] = '{8'h83, 32'h0000_0008, 32'hFFFF_FFFF, 1, 0,  0, 32'h0,         8'h02, 4'h3, 16};
    vecs[7] = '{8'h00, 32'h0000_0010, 32'h0,         1, 1,  0, 32'h1122_3344, 8'h00, 4'h0, 2};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_outreq", {31'd0, outreq}, 32'd0);
    check("rst_outaddr", outaddr, 32'd0);
    check("rst_outwdata", outwdata, 32'd0);
    check("rst_outwstrb", {28'd0, outwstrb}, 32'd0);
    check("rst_outwr", {31'd0, outwr}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    #2 rstn = 1'b1;
    #1 check("in_ready_before_clk", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("in_ready_after_clk", {31'd0, in_ready}, 32'd1);

    // Table of transactions
    for (int i = 0; i < 8; i++) apply(vecs[i]);

    // Timeout held under backpressure; late ack during RESP must be ignored
    out_ready = 1'b0;
    p0 = req_pulses;
    send_cmd(8'h00, 32'h0000_0300, 32'h0);
    wait_req();
    wait_out_valid();
    repeat (4) @(negedge clk);
    outack = 1'b1; outrdata = 32'h5555_AAAA;
    @(negedge clk);
    outack = 1'b0; outrdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      check("bp_tmo_out_data", {24'd0, out_data}, 32'h02);
      @(negedge clk);
    end
    check("late_ack_state", {29'd0, dbg_state}, 32'd5);
    exp_q.push_back(8'h02);
    recv_all();
    check("late_ack_no_req", req_pulses - p0, 32'd1);

    // Backpressure on a middle read-data byte
    out_ready = 1'b0;
    send_cmd(8'h00, 32'h0000_0400, 32'h0);
    wait_req();
    drive_ack(1, 1'b0, 32'hCAFE_F00D);
    wait_out_valid();
    check("bp_status", {24'd0, out_data}, 32'h00);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_data", {24'd0, out_data}, 32'h0D);
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
    end
    exp_q.push_back(8'h0D); exp_q.push_back(8'hF0);
    exp_q.push_back(8'hFE); exp_q.push_back(8'hCA);
    recv_all();

    // Reset asserted during WAIT
    send_cmd(8'h00, 32'h0000_0500, 32'h0);
    wait_req();
    repeat (2) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("wrst_outreq", {31'd0, outreq}, 32'd0);
    check("wrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("wrst_in_ready", {31'd0, in_ready}, 32'd0);
    check("wrst_state", {29'd0, dbg_state}, 32'd0);
    check("wrst_outaddr", outaddr, 32'd0);
    @(negedge clk);
    check("wrst_outreq_hold", {31'd0, outreq}, 32'd0);
    #2 rstn = 1'b1;
    @(negedge clk);
    check("wrst_in_ready_rel", {31'd0, in_ready}, 32'd1);

    // Partial command discarded by reset, then a normal read
    p0 = req_pulses;
    send_byte(8'h8F);
    send_byte(8'h11);
    send_byte(8'h22);
    #2 rstn = 1'b0;
    @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    check("partial_no_req", req_pulses - p0, 32'd0);
    rv = vecs[1];
    apply(rv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/dbg_bus_master.md
DBG_BUS_MASTER -- requirements
Module: dbg_bus_master

Interface
REQ-001 SHALL have parameter: TIMEOUT, 1023, cycles to wait for outack after outreq before aborting.
REQ-002 SHALL have port: clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port: rstn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: in_valid  input  1  command byte valid.
REQ-005 SHALL have port: in_data  input  8  command byte.
REQ-006 SHALL have port: in_ready  output  1  command byte accepted when in_valid&in_ready.
REQ-007 SHALL have port: out_valid  output  1  response byte valid.
REQ-008 SHALL have port: out_data  output  8  response byte.
REQ-009 SHALL have port: out_ready  input  1  response byte consumed when out_valid&out_ready.
REQ-010 SHALL have port: outreq  output  1  single-cycle bus request pulse.
REQ-011 SHALL have ports: outwr output 1 write flag; outaddr output 32 byte address; outwdata output 32 write data; outwstrb output 4 byte enables.
REQ-012 SHALL have ports: outack input 1 single-cycle completion; outerr input 1 error, valid with outack; outrdata input 32 read data, valid with outack.

Function
REQ-013 SHALL run FSM states CMD, ADDR, DATA, REQ, WAIT, RESP.
REQ-014 SHALL, in CMD, accept one byte: bit7 = wr, bits3:0 = wstrb, bits6:4 ignored; go to ADDR.
REQ-015 SHALL, in ADDR, accept 4 bytes little-endian into outaddr; then DATA if wr, else REQ.
REQ-016 SHALL, in DATA, accept 4 bytes little-endian into outwdata; then REQ.
REQ-017 SHALL drive in_ready=1 only in CMD, ADDR, DATA; byte counter 2 bits, wraps 3->0 on state exit.
REQ-018 SHALL drive outwstrb = cmd[3:0] for writes, 4'b0000 for reads; outwr = cmd[7].
REQ-019 SHALL, in REQ, assert outreq for exactly one cycle, then enter WAIT; outaddr/outwdata/outwr/outwstrb held stable from REQ until WAIT exits.
REQ-020 SHALL ignore outack in the REQ cycle; outack sampled only in WAIT.
REQ-021 SHALL, in WAIT, count cycles from 0; on outack latch outerr and outrdata, go to RESP.
REQ-022 SHALL, when counter reaches TIMEOUT without outack, go to RESP with status timeout; outack in that same cycle wins (normal completion).
REQ-023 SHALL discard outack arriving outside WAIT (late ack after timeout) with no state change.
REQ-024 SHALL, in RESP, emit status byte: 8'h00 ok, 8'h01 outerr, 8'h02 timeout; then, for reads with status ok or err, 4 outrdata bytes little-endian; writes and timeouts emit status only.
REQ-025 SHALL hold out_valid and out_data stable until out_ready; advance one byte per handshake; return to CMD after last byte.
REQ-026 SHALL keep out_valid=0 outside RESP and in_ready=0 during REQ/WAIT/RESP (one transaction outstanding max).

Reset
REQ-027 SHALL, on rstn low at any time including mid-transaction, asynchronously force state CMD, outreq=0, out_valid=0, in_ready=0 until first clk after release, counters 0, outaddr/outwdata/outwstrb/outwr=0.
REQ-028 SHALL drive in_ready=1 on first rising clk after rstn deasserts.
REQ-029 SHALL NOT issue outreq while rstn low; partially received commands discarded.

Verification
REQ-030 Write: bytes 8F,00,01,00,00,78,56,34,12; ack 3 cycles after outreq, outerr=0 -> one outreq pulse, outaddr=32'h00000100, outwdata=32'h12345678, outwstrb=F, outwr=1; response 00.
REQ-031 Read: bytes 00,04,02,00,00; ack with outrdata=32'hDEADBEEF, outerr=0 -> outwstrb=0, outwr=0, outaddr=32'h00000204; response 00,EF,BE,AD,DE.
REQ-032 Error: read to 32'h00001000, ack with outerr=1, outrdata=0 -> response 01,00,00,00,00.
REQ-033 Timeout: TIMEOUT=15, no ack -> response 02 after 15 WAIT cycles; ack injected 5 cycles later ignored; next command processes normally.
REQ-034 Backpressure/reset: out_ready held 0 for 10 cycles -> out_data stable, no byte lost; rstn pulsed low during WAIT -> outreq=0, out_valid=0, next command after release completes normally.
